pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage; successor of the basic step/set PC.
- Adds a valid/ready handshake to fetch, prioritised trap/branch redirects, halt/resume, a return-address stack (RAS) for call/return prediction, and a redirect-target misalignment check.
- Sits between the redirect sources (execute, trap unit) and the instruction fetch unit.

---
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with handshake, redirects,
// halt/resume, return-address stack and redirect misalignment check.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   fetch_valid/ready, fetch_pc  fetch request handshake
//   step_size, call_push,
//   ret_pop                      info on the instruction at fetch_pc
//   branch_valid/pc              execute redirect
//   trap_valid/pc                trap unit redirect (highest priority)
//   halt                         stop issuing fetches
//   misalign_err/addr            one-cycle misaligned-target report
//   ras_empty                    RAS holds no entries
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              IALIGN       = 16
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic [2:0]      step_size,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic            ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] AMASK =
    (IALIGN == 32) ? XLEN'(3) : XLEN'(1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            fire;
  logic            redirect;
  logic            empty;
  logic            full;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] seq_pc;

  assign fetch_valid   = valid_q;
  assign fetch_pc      = pc_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;
  assign ras_empty     = empty;

  always_comb begin
    fire     = valid_q & fetch_ready;
    redirect = trap_valid | branch_valid;
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(RAS_DEPTH));
    tgt      = trap_valid ? trap_pc : branch_pc;
    step     = (IALIGN == 16 && step_size == 3'd2)
             ? XLEN'(2) : XLEN'(4);
    seq_pc   = pc_q + step;

    pc_d   = pc_q;
    err_d  = 1'b0;
    addr_d = addr_q;
    ras_d  = ras_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;

    if (redirect) begin
      // Winning target loads with low bits cleared.
      pc_d  = tgt & ~AMASK;
      err_d = |(tgt & AMASK);
      if (err_d)
        addr_d = tgt;
      if (trap_valid)
        cnt_d = '0;
    end else if (fire) begin
      pc_d = seq_pc;
      if (ret_pop && !empty) begin
        pc_d = ras_q[ptr_q];
        if (call_push) begin
          // Call+return: swap top in place.
          ras_d[ptr_q] = seq_pc;
        end else begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else if (call_push) begin
        // Circular push: overwrites oldest when full.
        ptr_d        = ptr_q + PW'(1);
        ras_d[ptr_d] = seq_pc;
        if (!full)
          cnt_d = cnt_q + CW'(1);
      end
    end

    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = halt ? HALTED : RUN;
      HALTED:  state_d = (!halt || redirect) ? RUN : HALTED;
      default: state_d = BOOT;
    endcase
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
      addr_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ras_q   <= ras_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random checks of pc_gen against
// a queue-based reference model of the fetch PC behaviour.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [2:0]  step_size;
  logic        call_push;
  logic        ret_pop;
  logic        branch_valid;
  logic [31:0] branch_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        ras_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h1000),
    .RAS_DEPTH(4),
    .IALIGN(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc),
    .step_size(step_size),
    .call_push(call_push),
    .ret_pop(ret_pop),
    .branch_valid(branch_valid),
    .branch_pc(branch_pc),
    .trap_valid(trap_valid),
    .trap_pc(trap_pc),
    .halt(halt),
    .misalign_err(misalign_err),
    .misalign_addr(misalign_addr),
    .ras_empty(ras_empty)
  );

  // Model: mode 0 boot, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_addr;
  logic [31:0] ras [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h1000;
    m_err  = 1'b0;
    m_addr = 32'h0;
    ras.delete();
  endtask

  task automatic check_outputs();
    chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    chk("misalign_addr", misalign_addr, m_addr);
    chk("ras_empty", 32'(ras_empty), 32'(ras.size() == 0));
  endtask

  task automatic idle();
    fetch_ready  = 1'b1;
    step_size    = 3'd4;
    call_push    = 1'b0;
    ret_pop      = 1'b0;
    branch_valid = 1'b0;
    branch_pc    = 32'h0;
    trap_valid   = 1'b0;
    trap_pc      = 32'h0;
    halt         = 1'b0;
  endtask

  // One clock: model next state from current inputs, then compare.
  task automatic cyc();
    int          n_mode;
    logic [31:0] n_pc;
    logic        n_err;
    logic [31:0] n_addr;
    logic [31:0] n_ras [$];
    logic [31:0] tgt;
    logic [31:0] seq;
    bit          red;
    bit          fire;
    n_ras  = ras;
    n_pc   = m_pc;
    n_addr = m_addr;
    n_err  = 1'b0;
    red    = trap_valid || branch_valid;
    fire   = (m_mode == 1) && fetch_ready;
    tgt    = trap_valid ? trap_pc : branch_pc;
    if (m_mode == 0)      n_mode = 1;
    else if (m_mode == 1) n_mode = halt ? 2 : 1;
    else                  n_mode = (!halt || red) ? 1 : 2;
    if (red) begin
      n_pc  = (tgt / 2) * 2;
      n_err = (tgt % 2) != 0;
      if (n_err) n_addr = tgt;
      if (trap_valid) n_ras.delete();
    end else if (fire) begin
      seq = m_pc + ((step_size == 3'd2) ? 32'd2 : 32'd4);
      if (ret_pop && ras.size() > 0) begin
        n_pc = ras[$];
        if (call_push) n_ras[n_ras.size()-1] = seq;
        else           void'(n_ras.pop_back());
      end else begin
        n_pc = seq;
        if (call_push) begin
          n_ras.push_back(seq);
          if (n_ras.size() > 4) void'(n_ras.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode;
    m_pc   = n_pc;
    m_err  = n_err;
    m_addr = n_addr;
    ras    = n_ras;
    check_outputs();
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] exp_ret [5];
    exp_ret[0] = 32'h114;
    exp_ret[1] = 32'h110;
    exp_ret[2] = 32'h10c;
    exp_ret[3] = 32'h108;
    exp_ret[4] = 32'h10c;

    idle();
    model_reset();
    #12;
    check_outputs();
    chk("reset_pc", fetch_pc, 32'h1000);
    rstn = 1'b1;
    #1;
    chk("boot_valid", 32'(fetch_valid), 32'd0);

    cyc();
    chk("run_pc0", fetch_pc, 32'h1000);
    cyc();
    chk("run_pc1", fetch_pc, 32'h1004);
    cyc();
    chk("run_pc2", fetch_pc, 32'h1008);

    fetch_ready = 1'b0;
    repeat (3) cyc();
    chk("stall_hold", fetch_pc, 32'h1008);
    branch_valid = 1'b1;
    branch_pc    = 32'h2000;
    cyc();
    chk("branch_stall", fetch_pc, 32'h2000);
    trap_valid = 1'b1;
    trap_pc    = 32'h3000;
    cyc();
    chk("trap_wins", fetch_pc, 32'h3000);

    idle();
    branch_valid = 1'b1;
    branch_pc    = 32'h100;
    cyc();
    idle();
    call_push = 1'b1;
    repeat (5) cyc();
    chk("calls_pc", fetch_pc, 32'h114);
    call_push = 1'b0;
    ret_pop   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ret_pc", fetch_pc, exp_ret[i]);
    end
    chk("ras_drained", 32'(ras_empty), 32'd1);

    idle();
    branch_valid = 1'b1;
    branch_pc    = 32'h2001;
    cyc();
    chk("mis_pc", fetch_pc, 32'h2000);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_addr", misalign_addr, 32'h2001);
    idle();
    cyc();
    chk("mis_pulse", 32'(misalign_err), 32'd0);

    p    = fetch_pc;
    halt = 1'b1;
    cyc();
    chk("halt_inc", fetch_pc, p + 32'd4);
    chk("halt_valid", 32'(fetch_valid), 32'd0);
    cyc();
    chk("halt_hold", fetch_pc, p + 32'd4);
    branch_valid = 1'b1;
    branch_pc    = 32'hFFFF_FFFE;
    cyc();
    chk("resume_valid", 32'(fetch_valid), 32'd1);
    idle();
    step_size = 3'd2;
    cyc();
    chk("wrap_pc", fetch_pc, 32'h0);

    idle();
    call_push = 1'b1;
    repeat (3) cyc();
    chk("ras_three", 32'(ras_empty), 32'd0);
    idle();
    trap_valid = 1'b1;
    trap_pc    = 32'h4000;
    cyc();
    chk("trap_flush", 32'(ras_empty), 32'd1);
    idle();
    ret_pop = 1'b1;
    cyc();
    chk("ret_empty", fetch_pc, 32'h4004);

    for (int i = 0; i < 400; i++) begin
      fetch_ready  = ($urandom_range(0, 9) < 7);
      step_size    = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
      call_push    = ($urandom_range(0, 4) == 0);
      ret_pop      = ($urandom_range(0, 4) == 0);
      branch_valid = ($urandom_range(0, 9) == 0);
      branch_pc    = $urandom;
      trap_valid   = ($urandom_range(0, 19) == 0);
      trap_pc      = $urandom;
      halt         = ($urandom_range(0, 9) == 0);
      cyc();
    end

    idle();
    call_push = 1'b1;
    cyc();
    cyc();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    idle();
    #10;
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fetch_ready = $urandom_range(0, 1) == 1;
      call_push   = $urandom_range(0, 2) == 0;
      ret_pop     = $urandom_range(0, 2) == 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
